// File: rtl/btb_assoc.sv
// ---------------------------------------------------------------------------
// btb_assoc
// Fully associative branch target buffer for the fetch stage.
//
// Every cycle the fetch PC is compared against all valid entries and the
// result (hit, target, direction, link flag, entry index) is registered.
// The execute stage trains the table through the update port: a matching
// entry has its target/link refreshed and its saturating direction counter
// stepped; otherwise a victim is allocated (lowest-index invalid entry,
// else the true-LRU entry). Any touched entry becomes MRU.
//
// Ports:
//   clock, reset         single posedge clock, synchronous active-high reset
//   lookup_valid/_pc     fetch-side lookup request
//   hit, hit_target, hit_taken, hit_link, hit_idx
//                        registered lookup result (payload holds on miss)
//   upd_valid/_pc/_target/_taken/_link
//                        resolved-branch training port
//   invalidate_all       clear every valid bit at the next edge
// ---------------------------------------------------------------------------
module btb_assoc #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        lookup_valid,
    input  logic [ADDR_W-1:0]           lookup_pc,
    output logic                        hit,
    output logic [ADDR_W-1:0]           hit_target,
    output logic                        hit_taken,
    output logic                        hit_link,
    output logic [$clog2(ENTRIES)-1:0]  hit_idx,
    input  logic                        upd_valid,
    input  logic [ADDR_W-1:0]           upd_pc,
    input  logic [ADDR_W-1:0]           upd_target,
    input  logic                        upd_taken,
    input  logic                        upd_link,
    input  logic                        invalidate_all
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // Weak-taken / weak-not-taken allocation values (1 / 0 when CNT_W=1).
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(2 ** (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(2 ** (CNT_W - 1) - 1);

    // Per-entry state
    logic              ent_valid_q [ENTRIES];
    logic              ent_valid_d [ENTRIES];
    logic [ADDR_W-1:0] ent_addr_q  [ENTRIES];
    logic [ADDR_W-1:0] ent_addr_d  [ENTRIES];
    logic [ADDR_W-1:0] ent_tgt_q   [ENTRIES];
    logic [ADDR_W-1:0] ent_tgt_d   [ENTRIES];
    logic              ent_link_q  [ENTRIES];
    logic              ent_link_d  [ENTRIES];
    logic [CNT_W-1:0]  ent_cnt_q   [ENTRIES];
    logic [CNT_W-1:0]  ent_cnt_d   [ENTRIES];
    logic [IDX_W-1:0]  ent_age_q   [ENTRIES];
    logic [IDX_W-1:0]  ent_age_d   [ENTRIES];

    // Registered lookup result
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] hit_target_q, hit_target_d;
    logic              hit_taken_q, hit_taken_d;
    logic              hit_link_q, hit_link_d;
    logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;

    // Combinational search results
    logic              lk_match_s;
    logic [IDX_W-1:0]  lk_idx_s;
    logic              up_match_s;
    logic [IDX_W-1:0]  up_match_idx_s;
    logic              any_inv_s;
    logic [IDX_W-1:0]  inv_idx_s;
    logic [IDX_W-1:0]  old_idx_s;
    logic [IDX_W-1:0]  up_idx_s;
    logic              upd_en_s;
    logic              lk_promote_s;
    logic              promote_en_s;
    logic [IDX_W-1:0]  promote_idx_s;
    logic [IDX_W-1:0]  promo_age_s;

    // Saturating step of a direction counter.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                  input logic tk);
        logic [CNT_W-1:0] r;
        if (tk) begin
            r = (c == CNT_MAX) ? c : c + CNT_W'(1);
        end else begin
            r = (c == CNT_W'(0)) ? c : c - CNT_W'(1);
        end
        return r;
    endfunction

    // Associative search for lookup/update matches and the allocation victim.
    // Descending loops leave the lowest matching index in each result.
    always_comb begin
        lk_match_s     = 1'b0;
        lk_idx_s       = '0;
        up_match_s     = 1'b0;
        up_match_idx_s = '0;
        any_inv_s      = 1'b0;
        inv_idx_s      = '0;
        old_idx_s      = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            lk_match_s     = lk_match_s | (ent_valid_q[i] && (ent_addr_q[i] == lookup_pc));
            lk_idx_s       = (ent_valid_q[i] && (ent_addr_q[i] == lookup_pc)) ? IDX_W'(i) : lk_idx_s;
            up_match_s     = up_match_s | (ent_valid_q[i] && (ent_addr_q[i] == upd_pc));
            up_match_idx_s = (ent_valid_q[i] && (ent_addr_q[i] == upd_pc)) ? IDX_W'(i) : up_match_idx_s;
            any_inv_s      = any_inv_s | !ent_valid_q[i];
            inv_idx_s      = !ent_valid_q[i] ? IDX_W'(i) : inv_idx_s;
            old_idx_s      = (ent_age_q[i] == IDX_W'(ENTRIES - 1)) ? IDX_W'(i) : old_idx_s;
        end
        up_idx_s = up_match_s ? up_match_idx_s : (any_inv_s ? inv_idx_s : old_idx_s);
    end

    // Arbitration: invalidate beats update; a lookup only promotes when idle.
    always_comb begin
        upd_en_s      = upd_valid && !invalidate_all && !reset;
        lk_promote_s  = lookup_valid && lk_match_s && !upd_valid && !invalidate_all;
        promote_en_s  = upd_en_s || lk_promote_s;
        promote_idx_s = upd_en_s ? up_idx_s : lk_idx_s;
        promo_age_s   = ent_age_q[promote_idx_s];
    end

    // Next entry contents: invalidate, write/train, and LRU promotion.
    always_comb begin
        ent_valid_d = ent_valid_q;
        ent_addr_d  = ent_addr_q;
        ent_tgt_d   = ent_tgt_q;
        ent_link_d  = ent_link_q;
        ent_cnt_d   = ent_cnt_q;
        ent_age_d   = ent_age_q;
        if (invalidate_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid_d[i] = 1'b0;
            end
        end else if (upd_en_s) begin
            ent_valid_d[up_idx_s] = 1'b1;
            ent_addr_d[up_idx_s]  = upd_pc;
            ent_tgt_d[up_idx_s]   = upd_target;
            ent_link_d[up_idx_s]  = upd_link;
            ent_cnt_d[up_idx_s]   = up_match_s ? cnt_step(ent_cnt_q[up_idx_s], upd_taken)
                                               : (upd_taken ? CNT_WT : CNT_WNT);
        end else begin
            ent_valid_d = ent_valid_q;
        end
        // Promotion touches every entry regardless of valid so ages stay a permutation.
        for (int i = 0; i < ENTRIES; i++) begin
            if (!promote_en_s) begin
                ent_age_d[i] = ent_age_q[i];
            end else if (IDX_W'(i) == promote_idx_s) begin
                ent_age_d[i] = '0;
            end else if (ent_age_q[i] < promo_age_s) begin
                ent_age_d[i] = ent_age_q[i] + IDX_W'(1);
            end else begin
                ent_age_d[i] = ent_age_q[i];
            end
        end
    end

    // Next registered lookup result; payload holds on miss or idle.
    always_comb begin
        hit_d = lookup_valid && lk_match_s;
        if (hit_d) begin
            hit_target_d = ent_tgt_q[lk_idx_s];
            hit_taken_d  = ent_cnt_q[lk_idx_s][CNT_W-1];
            hit_link_d   = ent_link_q[lk_idx_s];
            hit_idx_d    = lk_idx_s;
        end else begin
            hit_target_d = hit_target_q;
            hit_taken_d  = hit_taken_q;
            hit_link_d   = hit_link_q;
            hit_idx_d    = hit_idx_q;
        end
    end

    // Control state: valid bits, LRU ages and lookup result (reset to known values).
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid_q[i] <= 1'b0;
                ent_age_q[i]   <= IDX_W'(i);
            end
            hit_q        <= 1'b0;
            hit_target_q <= '0;
            hit_taken_q  <= 1'b0;
            hit_link_q   <= 1'b0;
            hit_idx_q    <= '0;
        end else begin
            ent_valid_q  <= ent_valid_d;
            ent_age_q    <= ent_age_d;
            hit_q        <= hit_d;
            hit_target_q <= hit_target_d;
            hit_taken_q  <= hit_taken_d;
            hit_link_q   <= hit_link_d;
            hit_idx_q    <= hit_idx_d;
        end
    end

    // Entry payload: not reset, only meaningful while the entry is valid.
    always_ff @(posedge clock) begin
        ent_addr_q <= ent_addr_d;
        ent_tgt_q  <= ent_tgt_d;
        ent_link_q <= ent_link_d;
        ent_cnt_q  <= ent_cnt_d;
    end

    assign hit        = hit_q;
    assign hit_target = hit_target_q;
    assign hit_taken  = hit_taken_q;
    assign hit_link   = hit_link_q;
    assign hit_idx    = hit_idx_q;

endmodule

// File: tb/tb_btb_assoc.sv
// ---------------------------------------------------------------------------
// tb_btb_assoc
// Directed, table-driven bench for btb_assoc (ENTRIES=4, ADDR_W=32, CNT_W=2).
// Each table row is one clock cycle of inputs plus the lookup result expected
// right after that edge. Payload fields are compared only when chk=1.
// ---------------------------------------------------------------------------
module tb_btb_assoc;

    logic        clock;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        hit;
    logic [31:0] hit_target;
    logic        hit_taken;
    logic        hit_link;
    logic [1:0]  hit_idx;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_link;
    logic        invalidate_all;

    int n_tests = 0;
    int n_fail  = 0;

    btb_assoc #(.ENTRIES(4), .ADDR_W(32), .CNT_W(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .lookup_pc      (lookup_pc),
        .hit            (hit),
        .hit_target     (hit_target),
        .hit_taken      (hit_taken),
        .hit_link       (hit_link),
        .hit_idx        (hit_idx),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_link       (upd_link),
        .invalidate_all (invalidate_all)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic        ulk;
        logic        inv;
        logic        lv;
        logic [31:0] lpc;
        logic        eh;
        logic [31:0] etgt;
        logic        etk;
        logic        elk;
        logic [1:0]  eidx;
        logic        chk;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rst, input logic uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic utk, input logic ulk,
                       input logic inv, input logic lv, input logic [31:0] lpc,
                       input logic eh, input logic [31:0] etgt, input logic etk,
                       input logic elk, input logic [1:0] eidx, input logic chk);
        vec_t v;
        v.rst = rst; v.uv = uv; v.upc = upc; v.utgt = utgt; v.utk = utk; v.ulk = ulk;
        v.inv = inv; v.lv = lv; v.lpc = lpc; v.eh = eh; v.etgt = etgt; v.etk = etk;
        v.elk = elk; v.eidx = eidx; v.chk = chk;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int r, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %0h expected %0h", r, nm, got, exp);
        end
    endtask

    initial begin
        // --- basic allocate + lookup, counter saturation, target/link refresh ---
        //   rst   uv    upc         utgt        utk   ulk   inv   lv    lpc         eh    etgt        etk   elk   eidx   chk
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b1); // 0
        row(1'b0, 1'b1, 32'h100,    32'h200,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b1); // 1 alloc cnt=2
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h100,    1'b1, 32'h200,    1'b1, 1'b0, 2'd0, 1'b1); // 2
        row(1'b0, 1'b1, 32'h100,    32'h204,    1'b1, 1'b1, 1'b0, 1'b1, 32'h100,    1'b1, 32'h200,    1'b1, 1'b0, 2'd0, 1'b1); // 3 cnt->3
        row(1'b0, 1'b1, 32'h100,    32'h204,    1'b1, 1'b1, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b1, 1'b1, 2'd0, 1'b1); // 4 cnt 3
        row(1'b0, 1'b1, 32'h100,    32'h204,    1'b1, 1'b1, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b1, 1'b1, 2'd0, 1'b1); // 5 cnt 3
        row(1'b0, 1'b1, 32'h100,    32'h204,    1'b0, 1'b1, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b1, 1'b1, 2'd0, 1'b1); // 6 sees 3 ->2
        row(1'b0, 1'b1, 32'h100,    32'h204,    1'b0, 1'b1, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b1, 1'b1, 2'd0, 1'b1); // 7 sees 2 ->1
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b0, 1'b1, 2'd0, 1'b1); // 8 sees 1
        row(1'b0, 1'b1, 32'h100,    32'h204,    1'b0, 1'b1, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b0, 1'b1, 2'd0, 1'b1); // 9 ->0
        row(1'b0, 1'b1, 32'h100,    32'h204,    1'b0, 1'b1, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b0, 1'b1, 2'd0, 1'b1); // 10 stays 0
        row(1'b0, 1'b1, 32'h100,    32'h204,    1'b1, 1'b1, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b0, 1'b1, 2'd0, 1'b1); // 11 sees 0 ->1
        row(1'b0, 1'b1, 32'h100,    32'h204,    1'b1, 1'b1, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b0, 1'b1, 2'd0, 1'b1); // 12 sees 1 ->2
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h100,    1'b1, 32'h204,    1'b1, 1'b1, 2'd0, 1'b1); // 13 sees 2
        // --- no bypass: same-cycle update and lookup of a new pc ---
        row(1'b0, 1'b1, 32'h300,    32'h380,    1'b0, 1'b0, 1'b0, 1'b1, 32'h300,    1'b0, 32'h204,    1'b1, 1'b1, 2'd0, 1'b1); // 14 miss, hold
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h300,    1'b1, 32'h380,    1'b0, 1'b0, 2'd1, 1'b1); // 15
        // --- invalidate_all beats a same-cycle update; lookup sees pre-clear ---
        row(1'b0, 1'b1, 32'h400,    32'h480,    1'b1, 1'b0, 1'b1, 1'b1, 32'h100,    1'b1, 32'h204,    1'b1, 1'b1, 2'd0, 1'b1); // 16
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h100,    1'b0, 32'h204,    1'b1, 1'b1, 2'd0, 1'b1); // 17
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h300,    1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 18
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h400,    1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 19
        row(1'b0, 1'b1, 32'h500,    32'h580,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 20
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h500,    1'b1, 32'h580,    1'b1, 1'b0, 2'd0, 1'b1); // 21 idx 0
        // --- LRU: A..D, promote A by lookup, E replaces B ---
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 22
        row(1'b0, 1'b1, 32'hA00,    32'hA80,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 23
        row(1'b0, 1'b1, 32'hB00,    32'hB80,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 24
        row(1'b0, 1'b1, 32'hC00,    32'hC80,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 25
        row(1'b0, 1'b1, 32'hD00,    32'hD80,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 26
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hA00,    1'b1, 32'hA80,    1'b1, 1'b0, 2'd0, 1'b1); // 27
        row(1'b0, 1'b1, 32'hE00,    32'hE80,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 28
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hB00,    1'b0, 32'hA80,    1'b1, 1'b0, 2'd0, 1'b1); // 29
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hA00,    1'b1, 32'hA80,    1'b1, 1'b0, 2'd0, 1'b1); // 30
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hC00,    1'b1, 32'hC80,    1'b1, 1'b1, 2'd2, 1'b1); // 31
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hD00,    1'b1, 32'hD80,    1'b0, 1'b0, 2'd3, 1'b1); // 32
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hE00,    1'b1, 32'hE80,    1'b1, 1'b0, 2'd1, 1'b1); // 33
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 32'hA00,    1'b0, 32'hE80,    1'b1, 1'b0, 2'd1, 1'b1); // 34 lv=0 holds
        // --- reset mid-operation while full; same-cycle update dropped ---
        row(1'b1, 1'b1, 32'h700,    32'h780,    1'b1, 1'b0, 1'b0, 1'b1, 32'hA00,    1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b1); // 35
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hA00,    1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b1); // 36
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hE00,    1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 37
        row(1'b0, 1'b1, 32'hF00,    32'hF80,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 38
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hF00,    1'b1, 32'hF80,    1'b0, 1'b1, 2'd0, 1'b1); // 39
        row(1'b0, 1'b1, 32'h1000,   32'h1080,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 40
        row(1'b0, 1'b1, 32'h1100,   32'h1180,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 41
        row(1'b0, 1'b1, 32'h1200,   32'h1280,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 42
        row(1'b0, 1'b1, 32'h1300,   32'h1380,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 43 evicts F
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h1300,   1'b1, 32'h1380,   1'b1, 1'b0, 2'd0, 1'b1); // 44
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'hF00,    1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 45
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h700,    1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 46
        // --- lookup hit with same-cycle update: only the update promotes ---
        row(1'b0, 1'b1, 32'h1100,   32'h1180,   1'b1, 1'b0, 1'b0, 1'b1, 32'h1000,   1'b1, 32'h1080,   1'b1, 1'b0, 2'd1, 1'b1); // 47
        row(1'b0, 1'b1, 32'h1400,   32'h1480,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 48 evicts G
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h1400,   1'b1, 32'h1480,   1'b0, 1'b0, 2'd1, 1'b1); // 49
        row(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h1000,   1'b0, 32'h0,      1'b0, 1'b0, 2'd0, 1'b0); // 50

        // Hand sequence: power-on reset with junk on every input.
        reset          = 1'b1;
        lookup_valid   = 1'b1;
        lookup_pc      = 32'h100;
        upd_valid      = 1'b1;
        upd_pc         = 32'h100;
        upd_target     = 32'hDEAD;
        upd_taken      = 1'b1;
        upd_link       = 1'b1;
        invalidate_all = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_hit",    -1, {31'd0, hit},       32'd0);
        check("rst_target", -1, hit_target,         32'd0);
        check("rst_taken",  -1, {31'd0, hit_taken}, 32'd0);
        check("rst_link",   -1, {31'd0, hit_link},  32'd0);
        check("rst_idx",    -1, {30'd0, hit_idx},   32'd0);

        foreach (vecs[r]) begin
            reset          = vecs[r].rst;
            upd_valid      = vecs[r].uv;
            upd_pc         = vecs[r].upc;
            upd_target     = vecs[r].utgt;
            upd_taken      = vecs[r].utk;
            upd_link       = vecs[r].ulk;
            invalidate_all = vecs[r].inv;
            lookup_valid   = vecs[r].lv;
            lookup_pc      = vecs[r].lpc;
            @(posedge clock);
            #1;
            check("hit", r, {31'd0, hit}, {31'd0, vecs[r].eh});
            if (vecs[r].chk) begin
                check("hit_target", r, hit_target,         vecs[r].etgt);
                check("hit_taken",  r, {31'd0, hit_taken}, {31'd0, vecs[r].etk});
                check("hit_link",   r, {31'd0, hit_link},  {31'd0, vecs[r].elk});
                check("hit_idx",    r, {30'd0, hit_idx},   {30'd0, vecs[r].eidx});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
